// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with framing markers.
//
// Words arrive on a valid/ready handshake. Each word is shifted out one bit per
// clock, with first/last markers. A one-word holding buffer lets back-to-back
// words go out with no idle bit between them.
//
// Parameters:
//   WIDTH     - word width in bits (>= 2)
//   MSB_FIRST - 1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous, active-high; clears all state
//   in_valid_i    - parallel_in_i holds a word to send
//   in_ready_o    - a word can be accepted this cycle
//   parallel_in_i - word to transmit
//   ser_out_o     - serial data bit (0 when ser_valid_o is low)
//   ser_valid_o   - ser_out_o carries a valid bit
//   ser_first_o   - current bit is the first bit of a word
//   ser_last_o    - current bit is the last bit of a word
//   busy_o        - a word is being shifted or is held
module piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] parallel_in_i,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             ser_first_o,
    output logic             ser_last_o,
    output logic             busy_o
);

    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sh_shifted;

    assign accept   = in_valid_i && !hold_full_q;
    assign last_bit = (cnt_q == LastCnt);

    // Move the shifter one position toward whichever end feeds ser_out_o.
    always_comb begin
        sh_shifted = sh_q;
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_d    = parallel_in_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!last_bit) begin
                    sh_d  = sh_shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d      = parallel_in_i;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Held word follows immediately; in_ready is low so no accept here.
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Word offered on the last-bit edge skips the hold register.
                    sh_d  = parallel_in_i;
                    cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // All outputs decode from registers only.
    always_comb begin
        ser_valid_o = (state_q == StShift);
        ser_out_o   = ser_valid_o && (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
        ser_first_o = ser_valid_o && (cnt_q == '0);
        ser_last_o  = ser_valid_o && last_bit;
        busy_o      = ser_valid_o || hold_full_q;
        in_ready_o  = !hold_full_q;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: two instances (MSB-first and LSB-first) share one
// stimulus stream. A word-queue reference model predicts every output each cycle.
module tb_piso_tx;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] parallel_in = '0;

    logic m_ready, m_out, m_valid, m_first, m_last, m_busy;
    logic l_ready, l_out, l_valid, l_first, l_last, l_busy;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of words not yet fully sent (front is on the wire).
    logic [W-1:0] mq[$];
    int           pos = 0;

    // Bits seen on each serial line, oldest in the higher positions.
    logic [15:0] m_stream, l_stream;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (m_ready),
        .parallel_in_i(parallel_in),
        .ser_out_o    (m_out),
        .ser_valid_o  (m_valid),
        .ser_first_o  (m_first),
        .ser_last_o   (m_last),
        .busy_o       (m_busy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (l_ready),
        .parallel_in_i(parallel_in),
        .ser_out_o    (l_out),
        .ser_valid_o  (l_valid),
        .ser_first_o  (l_first),
        .ser_last_o   (l_last),
        .busy_o       (l_busy)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare both DUTs against the model's view of the current cycle.
    // Packed as {ready, valid, first, last, busy, out}.
    task automatic check_outputs(input string tag);
        logic       v, b_msb, b_lsb;
        logic [W-1:0] w;
        v     = (mq.size() > 0);
        w     = v ? mq[0] : '0;
        b_msb = v ? w[W-1-pos] : 1'b0;
        b_lsb = v ? w[pos] : 1'b0;
        check_eq({tag, "_msb"},
                 {10'd0, m_ready, m_valid, m_first, m_last, m_busy, m_out},
                 {10'd0, mq.size() < 2, v, v && pos == 0, v && pos == W - 1, v, b_msb});
        check_eq({tag, "_lsb"},
                 {10'd0, l_ready, l_valid, l_first, l_last, l_busy, l_out},
                 {10'd0, mq.size() < 2, v, v && pos == 0, v && pos == W - 1, v, b_lsb});
    endtask

    // One clock edge: the model applies the handshake with pre-edge inputs.
    task automatic step(input string tag);
        bit           acc;
        logic [W-1:0] word;
        acc  = in_valid && (mq.size() < 2);
        word = parallel_in;
        @(posedge clk);
        if (mq.size() > 0) begin
            pos++;
            if (pos == W) begin
                void'(mq.pop_front());
                pos = 0;
            end
        end
        if (acc) mq.push_back(word);
        #1;
        check_outputs(tag);
        if (m_valid) m_stream = {m_stream[14:0], m_out};
        if (l_valid) l_stream = {l_stream[14:0], l_out};
    endtask

    // Assert reset between edges, check immediate clearing, hold across one edge.
    task automatic do_reset();
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        mq.delete();
        pos = 0;
        #1;
        check_outputs("reset");
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        in_valid    = v;
        parallel_in = d;
    endtask

    task automatic clear_streams();
        m_stream = '0;
        l_stream = '0;
    endtask

    initial begin
        #12;
        do_reset();

        // Single word 1011.
        clear_streams();
        drive(1'b1, 4'b1011);
        step("single");
        drive(1'b0, '0);
        for (int i = 0; i < 5; i++) step("single");
        check_eq("single_msb_bits", m_stream, 16'b1011);
        check_eq("single_lsb_bits", l_stream, 16'b1101);

        // Back-to-back A then 5.
        clear_streams();
        drive(1'b1, 4'hA);
        step("b2b");
        drive(1'b1, 4'h5);
        step("b2b");
        drive(1'b0, '0);
        for (int i = 0; i < 8; i++) step("b2b");
        check_eq("b2b_msb_bits", m_stream, 16'b1010_0101);

        // Three words with in_valid held high until each is taken.
        clear_streams();
        for (int k = 1; k <= 3; k++) begin
            int budget;
            bit taken;
            budget = 10;
            taken  = 1'b0;
            drive(1'b1, W'(k));
            while (!taken && budget > 0) begin
                taken = (mq.size() < 2);
                step("three");
                budget--;
            end
            check_eq("three_accept_in_budget", {15'd0, taken}, 16'd1);
        end
        drive(1'b0, '0);
        for (int i = 0; i < 12; i++) step("three");
        check_eq("three_msb_bits", m_stream[11:0], 16'h123);

        // Reset after two bits of C, then 9.
        drive(1'b1, 4'hC);
        step("rst_mid");
        drive(1'b0, '0);
        step("rst_mid");
        step("rst_mid");
        do_reset();
        clear_streams();
        drive(1'b1, 4'h9);
        step("after_rst");
        check_eq("after_rst_first", {14'd0, m_first, m_out}, 16'b11);
        drive(1'b0, '0);
        for (int i = 0; i < 5; i++) step("after_rst");
        check_eq("after_rst_bits", m_stream, 16'b1001);

        // LSB-first 0001.
        clear_streams();
        drive(1'b1, 4'b0001);
        step("lsb");
        drive(1'b0, '0);
        for (int i = 0; i < 5; i++) step("lsb");
        check_eq("lsb_bits", l_stream, 16'b1000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), W'($urandom));
            step("rand");
            if ($urandom_range(0, 249) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
